// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency MUL/DIV with HI/LO registers.
// Division is compiled in only when MDU_DIV_EN is defined.
module mdu_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
`ifdef MDU_DIV_EN
  localparam logic [1:0] DIV  = 2'd2;
`endif

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;

  logic        is_signed;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;

  assign is_signed = ~mdop[0];

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact.
  assign ext_a = {{32{is_signed & A[31]}}, A};
  assign ext_b = {{32{is_signed & B[31]}}, B};
  assign prod  = ext_a * ext_b;

`ifdef MDU_DIV_EN
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] q_res;
  logic [31:0] r_res;
  logic        neg_q;
  logic        neg_r;

  // Divide magnitudes, then restore signs; 0x80000000/-1 falls out naturally.
  assign neg_q = is_signed & (A[31] ^ B[31]);
  assign neg_r = is_signed & A[31];
  assign dvd   = (is_signed & A[31]) ? -A : A;
  assign dvs   = (is_signed & B[31]) ? -B : B;
  assign quo   = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
  assign rem   = (dvs == 32'd0) ? 32'd0 : dvd % dvs;
  assign q_res = neg_q ? -quo : quo;
  assign r_res = neg_r ? -rem : rem;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (mdop)
              3'd0, 3'd1: begin
                pend_hi <= prod[63:32];
                pend_lo <= prod[31:0];
                cnt     <= CW'(MUL_LAT);
                busy    <= 1'b1;
                state   <= MUL;
              end
`ifdef MDU_DIV_EN
              3'd2, 3'd3: begin
                // Divide by zero recommits the current HI/LO unchanged.
                if (B == 32'd0) begin
                  pend_hi <= hi;
                  pend_lo <= lo;
                end else begin
                  pend_hi <= r_res;
                  pend_lo <= q_res;
                end
                cnt   <= CW'(DIV_LAT);
                busy  <= 1'b1;
                state <= DIV;
              end
`endif
              3'd4: hi <= A;
              3'd5: lo <= A;
              default: ;
            endcase
          end
        end
`ifdef MDU_DIV_EN
        MUL, DIV: begin
`else
        MUL: begin
`endif
          if (cnt == CW'(1)) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: directed and random steps against an arithmetic
// reference model of HI/LO and busy timing.
module tb_mdu_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdop  (mdop),
    .A     (a_in),
    .B     (b_in),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  int          busy_left = 0;
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;
  logic [31:0] p_hi = 0;
  logic [31:0] p_lo = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, busy_left > 0});
    check({tag, ".hi"}, hi, m_hi);
    check({tag, ".lo"}, lo, m_lo);
  endtask

  // One clock edge of architectural behaviour.
  task automatic model(input bit s, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    longint q;
    longint r;
    logic [63:0] p;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (s) begin
      case (op)
        3'd0: begin
          p = longint'($signed(a)) * longint'($signed(b));
          {p_hi, p_lo} = p;
          busy_left = MUL_LAT;
        end
        3'd1: begin
          p = {32'd0, a} * {32'd0, b};
          {p_hi, p_lo} = p;
          busy_left = MUL_LAT;
        end
        3'd2, 3'd3: begin
          if (DIV_EN) begin
            if (b == 0) begin
              p_hi = m_hi;
              p_lo = m_lo;
            end else begin
              if (op == 3'd2) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
              end else begin
                q = longint'({32'd0, a}) / longint'({32'd0, b});
                r = longint'({32'd0, a}) % longint'({32'd0, b});
              end
              p_lo = q[31:0];
              p_hi = r[31:0];
            end
            busy_left = DIV_LAT;
          end
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit s, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input string tag);
    start = s;
    mdop  = op;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    model(s, op, a, b);
    start = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 32'd0, tag);
  endtask

  task automatic model_reset();
    busy_left = 0;
    m_hi = 0;
    m_lo = 0;
    p_hi = 0;
    p_lo = 0;
  endtask

  logic [31:0] ra;
  logic [31:0] rb;
  logic [31:0] specials [6];

  initial begin
    specials[0] = 32'h8000_0000;
    specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h0000_0000;
    specials[3] = 32'h0000_0001;
    specials[4] = 32'h7FFF_FFFF;
    specials[5] = 32'hFFFF_FFFE;

    reset = 1'b1;
    start = 1'b0;
    mdop  = 3'd0;
    a_in  = 32'd0;
    b_in  = 32'd0;
    #12;
    model_reset();
    check_all("reset");
    reset = 1'b0;

    step(1'b1, 3'd4, 32'h1234_5678, 32'd0, "mthi");
    check("mthi.lit", hi, 32'h1234_5678);
    step(1'b1, 3'd5, 32'hCAFE_F00D, 32'd0, "mtlo");

    step(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, "mult");
    idle(MUL_LAT, "mult.wait");
    check("mult.hi.lit", hi, 32'hFFFF_FFFF);
    check("mult.lo.lit", lo, 32'hFFFF_FFFA);

    step(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
    idle(MUL_LAT, "multu.wait");
    check("multu.hi.lit", hi, 32'hFFFF_FFFE);
    check("multu.lo.lit", lo, 32'h0000_0001);

    step(1'b1, 3'd0, 32'd1000, 32'd1000, "mult2");
    step(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, "mtlo.busy");
    step(1'b1, 3'd1, 32'd7, 32'd9, "mult.busy");
    idle(MUL_LAT, "mult2.wait");

    step(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, "div");
    idle(DIV_LAT, "div.wait");
    step(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div.ovf");
    idle(DIV_LAT, "div.ovf.wait");
    step(1'b1, 3'd3, 32'd7, 32'd0, "divu.zero");
    idle(DIV_LAT, "divu.zero.wait");
    step(1'b1, 3'd2, 32'd8, 32'd2, "div.8.2");
    idle(DIV_LAT, "div.8.2.wait");
    step(1'b1, 3'd6, 32'h1111_1111, 32'd1, "nop6");
    step(1'b1, 3'd7, 32'h2222_2222, 32'd1, "nop7");

    step(1'b1, 3'd0, 32'h0001_0000, 32'h0001_0000, "mult.rst");
    idle(2, "mult.rst.wait");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst.async");
    #10;
    check_all("rst.held");
    reset = 1'b0;
    idle(MUL_LAT + 2, "rst.nocommit");

    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)]
                                       : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)]
                                       : $urandom;
      step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
           ra, rb, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 5, busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_LAT, default 10, busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  issue strobe for mdop, sampled on rising edge.
REQ-006 SHALL have port mdop  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 SHALL have port A  input  32  rs operand / dividend / MTHI-MTLO source.
REQ-008 SHALL have port B  input  32  rt operand / divisor.
REQ-009 SHALL have port busy  output  1  registered, high while a MUL/DIV sequence is in flight.
REQ-010 SHALL have port hi  output  32  current HI register value, direct from register.
REQ-011 SHALL have port lo  output  32  current LO register value, direct from register.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV with a down-counter cnt of width ceil(log2(max(MUL_LAT,DIV_LAT)+1)).
REQ-013 SHALL, in IDLE with start=1 and mdop in {0,1}, capture the 64-bit product into pending regs, load cnt=MUL_LAT, go to MUL.
REQ-014 SHALL, in IDLE with start=1 and mdop in {2,3}, capture quotient/remainder into pending regs, load cnt=DIV_LAT, go to DIV.
REQ-015 SHALL assert busy from the first edge after the accepted start for exactly MUL_LAT or DIV_LAT cycles.
REQ-016 SHALL decrement cnt each cycle in MUL/DIV; on the edge where cnt reaches 0, write pending {HI,LO}, clear busy, return to IDLE in the same edge.
REQ-017 SHALL keep hi/lo unchanged during busy; new values visible the cycle busy falls.
REQ-018 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned 32x32->64, HI = bits 63:32, LO = bits 31:0.
REQ-019 SHALL compute DIV signed, quotient truncated toward zero to LO, remainder carrying dividend's sign to HI; DIVU unsigned.
REQ-020 SHALL, for DIV with A=0x80000000, B=0xFFFFFFFF, produce LO=0x80000000, HI=0x00000000.
REQ-021 SHALL, for divisor B=0, still run DIV_LAT busy cycles and leave HI/LO unchanged.
REQ-022 SHALL, in IDLE with start=1 and mdop=4 (5), write A into HI (LO) at that edge, zero latency, busy stays 0.
REQ-023 SHALL ignore start (any mdop) while busy=1; no capture, no counter reload, no HI/LO write.
REQ-024 SHALL treat mdop 6-7 as no-op with no state change.

Reset
REQ-025 SHALL on reset=1, independent of clk, force state IDLE, cnt=0, busy=0, hi=0, lo=0, pending regs=0.
REQ-026 SHALL abandon any in-flight sequence on reset without committing its result.
REQ-027 SHALL accept start on the first rising edge after reset deasserts.

Configuration
REQ-028 SHALL use macro MDU_DIV_EN to compile division in or out.
REQ-029 SHALL, with MDU_DIV_EN defined, implement DIV/DIVU per REQ-014, REQ-019..REQ-021.
REQ-030 SHALL, without MDU_DIV_EN, omit divider logic and DIV state; mdop 2/3 act as no-op per REQ-024, busy stays 0.

Verification
REQ-031 SHALL test MULT A=0xFFFFFFFE(-2), B=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 SHALL test MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 SHALL test DIV A=-7, B=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU A=7, B=0 -> hi/lo unchanged after 10 cycles.
REQ-034 SHALL test MTHI A=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy=0; MTLO issued during MULT busy -> lo unchanged by it.
REQ-035 SHALL test reset asserted at busy cycle 3 of a MULT -> busy=0, hi=lo=0 immediately, no commit after release.
REQ-036 SHALL test build without MDU_DIV_EN: DIV A=8, B=2 -> busy stays 0, hi/lo unchanged.
